// File: rtl/par_frame_pkg.sv
// Shared constants for the serial frame receiver.
// State encoding and bit-counter width used by par_frame_ctrl and par_shift_acc.
package par_frame_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int MAX_DATA_W = 32;
    localparam int CNT_W      = $clog2(MAX_DATA_W) + 1;

endpackage

// File: rtl/par_shift_acc.sv
// Data shift register, running parity and bit counter for one frame.
// Ports: clk, rst, clr (restart frame), shift_en, bit_in -> word, parity, last_bit.
module par_shift_acc
    import par_frame_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] word,
    output logic              parity,
    output logic              last_bit
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (clr) begin
            shreg_d = '0;
            acc_d   = 1'b0;
            cnt_d   = '0;
        end else if (shift_en) begin
            // LSB first: bit number cnt lands at position cnt
            for (int i = 0; i < DATA_W; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    shreg_d[i] = bit_in;
                end
            end
            acc_d = acc_q ^ bit_in;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word     = shreg_q;
    assign parity   = acc_q;
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/par_frame_ctrl.sv
// Serial frame receiver: start, DATA_W bits LSB first, parity, stop; words out on valid/ready.
// Ports: clk, rst, ser_in, out_ready -> data_out, out_valid, par_err, frm_err, ovr_err, busy.
module par_frame_ctrl
    import par_frame_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter bit ODD_PAR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              ovr_err,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              ovr_q, ovr_d;

    logic              clr, shift_en;
    logic [DATA_W-1:0] word;
    logic              parity, last_bit;

    par_shift_acc #(.DATA_W(DATA_W)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .bit_in   (ser_in),
        .word     (word),
        .parity   (parity),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!ser_in) state_d = ST_DATA;
            ST_DATA:   if (last_bit) state_d = ST_PARITY;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr      = (state_q == ST_IDLE);
        shift_en = (state_q == ST_DATA);
        busy     = (state_q != ST_IDLE);
    end

    always_comb begin
        perr_d  = perr_q;
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
        if (state_q == ST_PARITY) begin
            perr_d = ((parity ^ ser_in) != ODD_PAR);
        end
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (state_q == ST_STOP) begin
            // Slot is free if empty or being drained this very cycle
            if (!valid_q || out_ready) begin
                data_d  = word;
                pe_d    = perr_q;
                fe_d    = !ser_in;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign par_err   = pe_q;
    assign frm_err   = fe_q;
    assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_par_frame_ctrl.sv
// Scoreboard bench for par_frame_ctrl (even-parity and odd-parity instances).
// Expected words are queued by the stimulus and popped by handshake monitors.
module tb_par_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_in = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] data_out;
    logic       out_valid, par_err, frm_err, ovr_err, busy;

    logic       ser_in2 = 1'b1;
    logic       out_ready2 = 1'b1;
    logic [7:0] data_out2;
    logic       out_valid2, par_err2, frm_err2, ovr_err2, busy2;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q  [$];
    logic [9:0] exp_q2 [$];

    int busy_cycles = 0;
    int ovr_cycles  = 0;
    int ovr_pulses  = 0;
    logic ovr_prev  = 1'b0;
    logic v_prev    = 1'b0;
    logic r_prev    = 1'b0;
    logic [7:0] d_prev = '0;

    always #5 clk = ~clk;

    par_frame_ctrl #(.DATA_W(8), .ODD_PAR(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .par_err   (par_err),
        .frm_err   (frm_err),
        .ovr_err   (ovr_err),
        .busy      (busy)
    );

    par_frame_ctrl #(.DATA_W(8), .ODD_PAR(1'b1)) dut_odd (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in2),
        .out_ready (out_ready2),
        .data_out  (data_out2),
        .out_valid (out_valid2),
        .par_err   (par_err2),
        .frm_err   (frm_err2),
        .ovr_err   (ovr_err2),
        .busy      (busy2)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor for the even-parity instance
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst) begin
            if (v_prev && !r_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", data_out, d_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", data_out, 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {par_err, frm_err, data_out}, e);
                end
            end
            if (busy) busy_cycles++;
            if (ovr_err) ovr_cycles++;
            if (ovr_err && !ovr_prev) ovr_pulses++;
        end
        ovr_prev = ovr_err;
        v_prev   = out_valid;
        r_prev   = out_ready;
        d_prev   = data_out;
    end

    // Monitor for the odd-parity instance
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && out_valid2 && out_ready2) begin
            if (exp_q2.size() == 0) begin
                check("unexpected_word_odd", data_out2, 32'hDEAD);
            end else begin
                e = exp_q2.pop_front();
                check("word_odd", {par_err2, frm_err2, data_out2}, e);
            end
        end
    end

    task automatic send_bit(input logic b);
        ser_in = b;
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the stop-bit edge; optionally raises out_ready
    // during the stop-bit cycle.
    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic sbit, input logic rdy_at_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        if (rdy_at_stop) out_ready = 1'b1;
        send_bit(sbit);
        ser_in = 1'b1;
    endtask

    task automatic send_frame2(input logic [7:0] d, input logic pbit);
        ser_in2 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            ser_in2 = d[i];
            @(posedge clk); #1;
        end
        ser_in2 = pbit;
        @(posedge clk); #1;
        ser_in2 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_flags", {par_err, frm_err, ovr_err}, 3'b000);

        // 1: clean 0xA5, even parity
        b0 = busy_cycles;
        exp_q.push_back({1'b0, 1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("t1_valid_at_stop", out_valid, 1'b1);
        check("t1_busy_done", busy, 1'b0);
        idle(1);
        check("t1_valid_one_cycle", out_valid, 1'b0);
        check("t1_busy_cycles", busy_cycles - b0, 10);

        // 2: wrong parity bit; odd-parity instance with parity 1
        exp_q.push_back({1'b1, 1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("t2_perr", par_err, 1'b1);
        idle(2);
        exp_q2.push_back({1'b0, 1'b0, 8'hA5});
        send_frame2(8'hA5, 1'b1);
        check("t2_odd_valid", out_valid2, 1'b1);
        idle(2);

        // 3: stop bit 0, then an immediate new frame
        exp_q.push_back({1'b0, 1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("t3_ferr", frm_err, 1'b1);
        check("t3_idle_after_bad_stop", busy, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h81});
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        check("t3_next_frame", data_out, 8'h81);
        idle(2);

        // 4: overrun with out_ready low
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'h11});
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check("t4_ovr_pulse", ovr_err, 1'b1);
        check("t4_held_data", data_out, 8'h11);
        check("t4_held_valid", out_valid, 1'b1);
        idle(1);
        check("t4_ovr_low", ovr_err, 1'b0);
        out_ready = 1'b1;
        idle(1);
        check("t4_valid_drop", out_valid, 1'b0);
        idle(2);

        // 5: ready rises exactly on the completing cycle
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'h11});
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h22});
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check("t5_no_ovr", ovr_err, 1'b0);
        check("t5_valid", out_valid, 1'b1);
        check("t5_data", data_out, 8'h22);
        idle(3);

        // 6: reset after the 4th data bit of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("t6_busy_mid", busy, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_outs",
              {data_out, out_valid, par_err, frm_err, ovr_err}, 12'h000);
        idle(12);
        check("t6_no_publish", out_valid, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("t6_clean_data", data_out, 8'h5A);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        check("queue_odd_drained", exp_q2.size(), 0);
        check("ovr_pulses", ovr_pulses, 1);
        check("ovr_cycles", ovr_cycles, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
